// File: rtl/fila_leitor.sv
// fila_leitor: drain side of the 8-entry byte queue; dequeues, captures and hands bytes downstream.
// Define FILA_LEITOR_CHECKSUM_EN to build the running XOR checksum register (otherwise checksum reads 0).
`timescale 1us/1ns

module fila_leitor #(
    parameter int DATA_W        = 8,
    parameter int LEN_W         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              drain_en,
    input  logic [DATA_W-1:0] q_data_in,
    input  logic [LEN_W-1:0]  q_len_in,
    output logic              q_deq_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        rx_count,
    output logic [7:0]        checksum
);

    // state  | meaning
    // IDLE   | waiting for drain_en and a non-empty queue
    // REQ    | dequeue pulse high for this single cycle
    // WAIT   | queue registers the dequeued byte
    // CAPT   | byte presented on q_data_in, captured at the exit edge
    // HOLD   | out_valid high, waiting for out_ready
    // SETTLE | lets the lagging q_len_in catch up before the next read
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, HOLD, SETTLE} state_t;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  settle_cnt, settle_nxt;
    logic              deq_nxt;
    logic              valid_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [7:0]        rx_nxt;
    logic              handshake;

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            q_deq_out  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            rx_count   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            q_deq_out  <= deq_nxt;
            out_valid  <= valid_nxt;
            out_data   <= data_nxt;
            rx_count   <= rx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        deq_nxt    = 1'b0;
        valid_nxt  = out_valid;
        data_nxt   = out_data;
        rx_nxt     = rx_count;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (drain_en && (q_len_in != '0)) begin
                    state_nxt = REQ;
                    deq_nxt   = 1'b1;
                end
            end
            REQ:  state_nxt = WAIT;
            WAIT: state_nxt = CAPT;
            CAPT: begin
                data_nxt  = q_data_in;
                valid_nxt = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    handshake  = 1'b1;
                    valid_nxt  = 1'b0;
                    rx_nxt     = rx_count + 8'd1;
                    settle_nxt = SETTLE_LOAD;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                // terminal count: leave when this decrement reaches zero
                if (settle_cnt <= CNT_W'(1)) begin
                    settle_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    settle_nxt = settle_cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef FILA_LEITOR_CHECKSUM_EN
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ 8'(out_data);
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_fila_leitor.sv
// tb_fila_leitor: drives fila_leitor from a behavioural queue and checks it against a timing model.
`timescale 1us/1ns

module tb_fila_leitor;

    localparam int SETTLE = 2;
`ifdef FILA_LEITOR_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    logic       clk_10KHz = 1'b0;
    logic       reset     = 1'b0;
    logic       drain_en  = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] q_data_in;
    logic [7:0] q_len_in;
    logic       q_deq_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic [7:0] rx_count;
    logic [7:0] checksum;

    fila_leitor #(.DATA_W(8), .LEN_W(8), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .drain_en  (drain_en),
        .q_data_in (q_data_in),
        .q_len_in  (q_len_in),
        .q_deq_out (q_deq_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .rx_count  (rx_count),
        .checksum  (checksum)
    );

    initial forever #50 clk_10KHz = ~clk_10KHz;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    always @(posedge clk_10KHz) cyc <= cyc + 1;

    // behavioural queue: registered data_out, length reported one edge late
    logic [7:0] fifo[$];
    logic [7:0] popped[$];
    always @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            fifo.delete();
            popped.delete();
            q_data_in <= 8'h00;
            q_len_in  <= 8'h00;
        end else begin
            q_len_in <= 8'(fifo.size());
            if (q_deq_out && fifo.size() > 0) begin
                q_data_in <= fifo[0];
                popped.push_back(fifo.pop_front());
            end
        end
    end

    // timing model: a read costs 3 edges to appear, then SETTLE cycles plus one idle cycle after acceptance
    logic       m_deq, m_valid;
    logic [7:0] m_data, m_rx, m_cks;
    int         arrive, cool;
    always @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            m_deq = 0; m_valid = 0; m_data = 0; m_rx = 0; m_cks = 0;
            arrive = 0; cool = 0;
        end else begin
            automatic bit idle_ok = !m_deq && arrive == 0 && !m_valid && cool == 0;
            automatic bit hs      = m_valid && out_ready;
            m_deq = 0;
            if (cool > 0) cool--;
            if (arrive > 0) begin
                arrive--;
                if (arrive == 0) begin
                    m_valid = 1;
                    m_data  = (popped.size() > 0) ? popped.pop_front() : 8'h00;
                end
            end
            if (hs) begin
                m_rx++;
                m_cks ^= m_data;
                m_valid = 0;
                cool    = SETTLE;
            end
            if (idle_ok && drain_en && q_len_in != 0) begin
                m_deq  = 1;
                arrive = 3;
            end
        end
    end

    int         deq_count  = 0;
    int         last_deq   = -1000;
    int         min_gap    = 1000;
    int         req_cyc    = 0;
    int         last_lat   = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk_10KHz) begin
        chk("q_deq_out", 32'(q_deq_out), 32'(m_deq));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("busy",      32'(busy),      32'(m_deq || arrive != 0 || m_valid || cool != 0));
        chk("rx_count",  32'(rx_count),  32'(m_rx));
        chk("checksum",  32'(checksum),  CKS_EN ? 32'(m_cks) : 32'h0);
        if (q_deq_out) begin
            deq_count++;
            if (cyc - last_deq < min_gap) min_gap = cyc - last_deq;
            last_deq = cyc;
            req_cyc  = cyc;
        end
        if (out_valid && !valid_prev) last_lat = cyc - req_cyc;
        if (out_valid && out_ready && !reset) got.push_back(out_data);
        valid_prev = out_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_10KHz);
        #5;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic wait_valid(input int max, input string name);
        int k = 0;
        while (!out_valid && k < max) begin
            @(negedge clk_10KHz);
            k++;
        end
        chk(name, 32'(out_valid), 32'h1);
        @(posedge clk_10KHz);
        #5;
    endtask

    task automatic wait_deq(input int max, input string name);
        int k = 0;
        while (!q_deq_out && k < max) begin
            @(negedge clk_10KHz);
            k++;
        end
        chk(name, 32'(q_deq_out), 32'h1);
        @(posedge clk_10KHz);
        #5;
    endtask

    initial begin
        #1 reset = 1'b1;
        drain_en  = 1'b1;
        out_ready = 1'b1;
        tick(2);
        reset = 1'b0;

        // empty queue never read
        tick(20);
        chk("t1_deq_count", 32'(deq_count), 32'd0);
        chk("t1_busy",      32'(busy),      32'd0);
        chk("t1_valid",     32'(out_valid), 32'd0);
        chk("t1_rx",        32'(rx_count),  32'd0);

        // single byte
        push(8'h3C);
        wait_valid(20, "t2_valid_timeout");
        tick(10);
        chk("t2_latency",   32'(last_lat),  32'd3);
        chk("t2_byte",      32'(got.size() > 0 ? got[0] : 8'h00), 32'h3C);
        chk("t2_deq_count", 32'(deq_count), 32'd1);
        chk("t2_rx",        32'(rx_count),  32'd1);
        chk("t2_cks",       32'(checksum),  CKS_EN ? 32'h3C : 32'h0);

        // three bytes back to back
        push(8'h11); push(8'h22); push(8'h33);
        tick(40);
        chk("t3_got_size",  32'(got.size()), 32'd4);
        if (got.size() >= 4) begin
            chk("t3_byte1", 32'(got[1]), 32'h11);
            chk("t3_byte2", 32'(got[2]), 32'h22);
            chk("t3_byte3", 32'(got[3]), 32'h33);
        end
        chk("t3_min_gap",   32'(min_gap),   32'd7);
        chk("t3_deq_count", 32'(deq_count), 32'd4);
        chk("t3_rx",        32'(rx_count),  32'd4);
        chk("t3_len",       32'(q_len_in),  32'd0);
        chk("t3_cks",       32'(checksum),  CKS_EN ? 32'h3C : 32'h0);

        // stall in HOLD with a second byte waiting
        out_ready = 1'b0;
        push(8'hA5); push(8'h5A);
        wait_valid(20, "t4_valid_timeout");
        repeat (10) begin
            @(negedge clk_10KHz);
            chk("t4_hold_valid", 32'(out_valid), 32'h1);
            chk("t4_hold_data",  32'(out_data),  32'hA5);
        end
        chk("t4_stall_deq", 32'(deq_count), 32'd5);
        @(posedge clk_10KHz);
        #5;
        out_ready = 1'b1;
        tick(30);
        chk("t4_rx",        32'(rx_count),  32'd6);
        if (got.size() >= 6) begin
            chk("t4_byte_a5", 32'(got[4]), 32'hA5);
            chk("t4_byte_5a", 32'(got[5]), 32'h5A);
        end
        chk("t4_deq_count", 32'(deq_count), 32'd6);
        chk("t4_cks",       32'(checksum),  CKS_EN ? 32'hC3 : 32'h0);

        // drain_en drops while the first of four bytes is in flight
        drain_en = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick(3);
        drain_en = 1'b1;
        wait_deq(10, "t5_deq_timeout");
        drain_en = 1'b0;
        tick(20);
        chk("t5_got_size",  32'(got.size()), 32'd7);
        if (got.size() >= 7) chk("t5_byte", 32'(got[6]), 32'h01);
        chk("t5_rx",        32'(rx_count),  32'd7);
        chk("t5_len",       32'(q_len_in),  32'd3);
        chk("t5_busy",      32'(busy),      32'd0);
        chk("t5_deq_count", 32'(deq_count), 32'd7);
        chk("t5_cks",       32'(checksum),  CKS_EN ? 32'hC2 : 32'h0);

        // reset while holding a byte
        out_ready = 1'b0;
        drain_en  = 1'b1;
        wait_valid(20, "t6_valid_timeout");
        @(posedge clk_10KHz);
        #20 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_rx",    32'(rx_count),  32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        chk("t6_rst_deq",   32'(q_deq_out), 32'd0);
        chk("t6_rst_cks",   32'(checksum),  32'd0);
        #10 reset = 1'b0;
        tick(10);
        chk("t6_idle_deq",  32'(deq_count), 32'd8);
        out_ready = 1'b1;
        push(8'h99);
        tick(20);
        chk("t6_rx",        32'(rx_count),  32'd1);
        if (got.size() >= 8) chk("t6_byte", 32'(got[7]), 32'h99);
        chk("t6_deq_count", 32'(deq_count), 32'd9);
        chk("t6_cks",       32'(checksum),  CKS_EN ? 32'h99 : 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
